// File: rtl/write_packer.sv
// write_packer: ingress packet framer for the SRAM controller.
// Takes one word per cycle from a sop/vld/eop stream, pops one free SRAM
// address per accepted word, writes the word and its next-pointer link, and
// emits one enqueue descriptor per packet (normal or discard) at end of packet.
module write_packer #(
  parameter int num_of_priorities  = 8,
  parameter int priority_width     = 3,
  parameter int address_width      = 12,
  parameter int arbiter_data_width = 64,
  parameter int max_words          = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_sop,
  input  logic                          wr_vld,
  input  logic                          wr_eop,
  input  logic [arbiter_data_width-1:0] wr_data,
  output logic                          wr_ready,
  input  logic [address_width-1:0]      free_addr,
  input  logic                          free_valid,
  output logic                          free_pop,
  output logic                          wea,
  output logic [address_width-1:0]      addra,
  output logic [arbiter_data_width-1:0] dina,
  output logic                          link_we,
  output logic [address_width-1:0]      link_addr,
  output logic [address_width-1:0]      link_data,
  output logic                          enq_valid,
  output logic [priority_width-1:0]     enq_priority,
  output logic [address_width-1:0]      enq_head,
  output logic [address_width-1:0]      enq_tail,
  output logic [address_width:0]        enq_len,
  output logic                          enq_drop,
  output logic                          pkt_drop
);

  localparam logic [address_width:0] max_len = (address_width + 1)'(max_words);

  if (num_of_priorities > (1 << priority_width) || max_words > (1 << address_width)) begin : g_param_check
    $error("write_packer: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;

  state_t                    state;
  state_t                    state_next;
  logic [address_width:0]    len;
  logic [address_width-1:0]  head;
  logic [address_width-1:0]  tail;
  logic [priority_width-1:0] prio;

  logic                      accept;
  logic                      overflow;
  logic                      close;
  logic                      drop_close;
  logic [address_width:0]    len_upd;
  logic [address_width-1:0]  head_upd;
  logic [address_width-1:0]  tail_upd;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: a new sop always (re)opens a packet
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (wr_sop) state_next = DATA;
      DATA: begin
        if (wr_sop)        state_next = DATA;
        else if (wr_eop)   state_next = IDLE;
        else if (overflow) state_next = DROP;
      end
      DROP: begin
        if (wr_sop)      state_next = DATA;
        else if (wr_eop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output/control decode. The accepted word is folded into len/head/tail
  // before eop handling, so a same-cycle vld+eop closes with the updated chain.
  always_comb begin
    accept     = !rst && (state == DATA) && wr_vld && free_valid && (len < max_len);
    overflow   = (state == DATA) && wr_vld && !(free_valid && (len < max_len));
    close      = (state != IDLE) && (wr_eop || wr_sop);
    drop_close = (state == DROP) || overflow || (wr_sop && !wr_eop);
    len_upd    = accept ? len + 1'b1 : len;
    tail_upd   = accept ? free_addr : tail;
    head_upd   = (accept && (len == '0)) ? free_addr : head;
    free_pop   = accept;
    wr_ready   = free_valid && (state != DROP);
  end

  // Packet bookkeeping, SRAM/link write stage and descriptor output
  always_ff @(posedge clk) begin
    if (rst) begin
      len          <= '0;
      head         <= '0;
      tail         <= '0;
      prio         <= '0;
      wea          <= 1'b0;
      addra        <= '0;
      dina         <= '0;
      link_we      <= 1'b0;
      link_addr    <= '0;
      link_data    <= '0;
      enq_valid    <= 1'b0;
      enq_priority <= '0;
      enq_head     <= '0;
      enq_tail     <= '0;
      enq_len      <= '0;
      enq_drop     <= 1'b0;
      pkt_drop     <= 1'b0;
    end else begin
      wea     <= accept;
      link_we <= accept && (len != '0);
      if (accept) begin
        addra     <= free_addr;
        dina      <= wr_data;
        link_addr <= tail;
        link_data <= free_addr;
      end

      len  <= len_upd;
      head <= head_upd;
      tail <= tail_upd;

      enq_valid <= close && (len_upd != '0);
      pkt_drop  <= close && (drop_close || (len_upd == '0));
      if (close) begin
        enq_priority <= prio;
        enq_head     <= head_upd;
        enq_tail     <= tail_upd;
        enq_len      <= len_upd;
        enq_drop     <= drop_close && (len_upd != '0);
        len          <= '0;
      end

      if (wr_sop) begin
        prio <= wr_data[priority_width-1:0];
        len  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_write_packer.sv
// Directed bench for write_packer: drives packet scenarios, logs SRAM writes,
// link writes and descriptors, and compares them with hand-computed values.
module tb_write_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_sop, wr_vld, wr_eop;
  logic [63:0] wr_data;
  logic        wr_ready;
  logic [11:0] free_addr;
  logic        free_valid;
  logic        free_pop;
  logic        wea;
  logic [11:0] addra;
  logic [63:0] dina;
  logic        link_we;
  logic [11:0] link_addr, link_data;
  logic        enq_valid;
  logic [2:0]  enq_priority;
  logic [11:0] enq_head, enq_tail;
  logic [12:0] enq_len;
  logic        enq_drop;
  logic        pkt_drop;

  int tests  = 0;
  int failed = 0;

  logic [11:0] wa_q[$];
  logic [63:0] wd_q[$];
  logic [23:0] lk_q[$];
  logic [40:0] enq_q[$];
  int          drops = 0;
  int          pops  = 0;

  write_packer #(
    .num_of_priorities (8),
    .priority_width    (3),
    .address_width     (12),
    .arbiter_data_width(64),
    .max_words         (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_sop      (wr_sop),
    .wr_vld      (wr_vld),
    .wr_eop      (wr_eop),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .free_addr   (free_addr),
    .free_valid  (free_valid),
    .free_pop    (free_pop),
    .wea         (wea),
    .addra       (addra),
    .dina        (dina),
    .link_we     (link_we),
    .link_addr   (link_addr),
    .link_data   (link_data),
    .enq_valid   (enq_valid),
    .enq_priority(enq_priority),
    .enq_head    (enq_head),
    .enq_tail    (enq_tail),
    .enq_len     (enq_len),
    .enq_drop    (enq_drop),
    .pkt_drop    (pkt_drop)
  );

  always #5 clk = ~clk;

  // Log every DUT-side event once per cycle, mid-cycle
  always @(negedge clk) begin
    if (wea) begin
      wa_q.push_back(addra);
      wd_q.push_back(dina);
    end
    if (link_we)   lk_q.push_back({link_addr, link_data});
    if (enq_valid) enq_q.push_back({enq_priority, enq_head, enq_tail, enq_len, enq_drop});
    if (pkt_drop)  drops++;
    if (free_pop)  pops++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] enq_word(input logic [2:0] p, input logic [11:0] h,
                                           input logic [11:0] t, input logic [12:0] l,
                                           input logic d);
    return {p, h, t, l, d};
  endfunction

  // One clock: the free-list model advances its head on every pop
  task automatic tick();
    logic pop;
    @(negedge clk);
    pop = free_pop;
    @(posedge clk);
    #1;
    if (pop) free_addr = free_addr + 12'd1;
  endtask

  task automatic idle(input int n);
    wr_sop = 1'b0; wr_vld = 1'b0; wr_eop = 1'b0; wr_data = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_sop(input logic [63:0] hdr);
    wr_sop = 1'b1; wr_vld = 1'b0; wr_eop = 1'b0; wr_data = hdr;
    tick();
    wr_sop = 1'b0; wr_data = '0;
  endtask

  task automatic send_word(input logic [63:0] d);
    wr_vld = 1'b1; wr_data = d;
    tick();
    wr_vld = 1'b0; wr_data = '0;
  endtask

  task automatic send_eop();
    wr_eop = 1'b1;
    tick();
    wr_eop = 1'b0;
  endtask

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); lk_q.delete(); enq_q.delete();
    drops = 0; pops = 0;
  endtask

  task automatic expect_counts(input string tag, input int nw, input int nl,
                               input int ne, input int nd, input int np);
    check({tag, "_writes"}, wa_q.size(), nw);
    check({tag, "_links"},  lk_q.size(), nl);
    check({tag, "_enqs"},   enq_q.size(), ne);
    check({tag, "_drops"},  drops, nd);
    check({tag, "_pops"},   pops, np);
  endtask

  task automatic expect_write(input string tag, input int i, input logic [11:0] a, input logic [63:0] d);
    check({tag, "_waddr"}, (i < wa_q.size()) ? wa_q[i] : 12'hfff, a);
    check({tag, "_wdata"}, (i < wd_q.size()) ? wd_q[i] : 64'hx, d);
  endtask

  task automatic expect_link(input string tag, input int i, input logic [11:0] a, input logic [11:0] d);
    check({tag, "_link"}, (i < lk_q.size()) ? lk_q[i] : 24'hffffff, {a, d});
  endtask

  task automatic expect_enq(input string tag, input int i, input logic [40:0] e);
    check({tag, "_enq"}, (i < enq_q.size()) ? enq_q[i] : '1, e);
  endtask

  task automatic expect_all_zero(input string tag);
    check({tag, "_wea"},      wea, 0);
    check({tag, "_addra"},    addra, 0);
    check({tag, "_dina"},     dina, 0);
    check({tag, "_link_we"},  link_we, 0);
    check({tag, "_link_a"},   {link_addr, link_data}, 0);
    check({tag, "_enq_v"},    enq_valid, 0);
    check({tag, "_enq_f"},    {enq_priority, enq_head, enq_tail, enq_len, enq_drop}, 0);
    check({tag, "_pkt_drop"}, pkt_drop, 0);
    check({tag, "_free_pop"}, free_pop, 0);
  endtask

  initial begin
    rst = 1'b1; wr_sop = 1'b0; wr_vld = 1'b0; wr_eop = 1'b0; wr_data = '0;
    free_addr = 12'd10; free_valid = 1'b1;
    tick(); tick();
    expect_all_zero("reset");
    check("reset_wr_ready", wr_ready, 1);
    rst = 1'b0;
    idle(1);
    clear_log();

    // Single 3-word packet, prio 5, addresses 10..12
    send_sop(64'd5);
    wr_vld = 1'b1; wr_data = 64'hD0;
    #1;
    check("t1_free_pop_comb", free_pop, 1);
    tick();
    wr_vld = 1'b0;
    send_word(64'hD1);
    send_word(64'hD2);
    send_eop();
    check("t1_enq_at_m1", enq_valid, 1);
    idle(1);
    check("t1_enq_one_cycle", enq_valid, 0);
    idle(2);
    expect_counts("t1", 3, 2, 1, 0, 3);
    expect_write("t1_w0", 0, 12'd10, 64'hD0);
    expect_write("t1_w1", 1, 12'd11, 64'hD1);
    expect_write("t1_w2", 2, 12'd12, 64'hD2);
    expect_link("t1_l0", 0, 12'd10, 12'd11);
    expect_link("t1_l1", 1, 12'd11, 12'd12);
    expect_enq("t1", 0, enq_word(3'd5, 12'd10, 12'd12, 13'd3, 1'b0));
    clear_log();

    // Back-to-back single-word packets, prio 0 then 7
    send_sop(64'd0);
    send_word(64'hB0);
    send_eop();
    send_sop(64'hFFFF_0007);
    send_word(64'hB1);
    send_eop();
    idle(3);
    expect_counts("t2", 2, 0, 2, 0, 2);
    expect_write("t2_w0", 0, 12'd13, 64'hB0);
    expect_write("t2_w1", 1, 12'd14, 64'hB1);
    expect_enq("t2_p0", 0, enq_word(3'd0, 12'd13, 12'd13, 13'd1, 1'b0));
    expect_enq("t2_p1", 1, enq_word(3'd7, 12'd14, 12'd14, 13'd1, 1'b0));
    clear_log();

    // Free list runs dry before word 2 of a 4-word packet
    send_sop(64'd2);
    send_word(64'hC0);
    free_valid = 1'b0;
    send_word(64'hC1);
    free_valid = 1'b1;
    check("t3_wr_ready_drop", wr_ready, 0);
    send_word(64'hC2);
    send_word(64'hC3);
    send_eop();
    idle(3);
    expect_counts("t3", 1, 0, 1, 1, 1);
    expect_write("t3_w0", 0, 12'd15, 64'hC0);
    expect_enq("t3", 0, enq_word(3'd2, 12'd15, 12'd15, 13'd1, 1'b1));
    clear_log();

    // Oversize: 65 words, only the first 64 are kept
    send_sop(64'd4);
    for (int i = 0; i < 65; i++) send_word(64'hA000 + 64'(i));
    send_eop();
    idle(3);
    expect_counts("t4", 64, 63, 1, 1, 64);
    for (int i = 0; i < 64; i++)
      expect_write("t4_w", i, 12'(16 + i), 64'hA000 + 64'(i));
    expect_link("t4_l_first", 0, 12'd16, 12'd17);
    expect_link("t4_l_last", 62, 12'd78, 12'd79);
    expect_enq("t4", 0, enq_word(3'd4, 12'd16, 12'd79, 13'd64, 1'b1));
    clear_log();

    // Missing eop: second sop closes the first packet as a discard
    send_sop(64'd1);
    send_word(64'hE0);
    send_word(64'hE1);
    send_sop(64'd3);
    send_word(64'hE2);
    send_eop();
    idle(3);
    expect_counts("t5", 3, 1, 2, 1, 3);
    expect_link("t5_l0", 0, 12'd80, 12'd81);
    expect_write("t5_w2", 2, 12'd82, 64'hE2);
    expect_enq("t5_drop", 0, enq_word(3'd1, 12'd80, 12'd81, 13'd2, 1'b1));
    expect_enq("t5_ok", 1, enq_word(3'd3, 12'd82, 12'd82, 13'd1, 1'b0));
    clear_log();

    // Reset after two accepted words, then a clean packet
    send_sop(64'd6);
    send_word(64'hF0);
    send_word(64'hF1);
    rst = 1'b1;
    tick();
    expect_all_zero("t6_rst");
    rst = 1'b0;
    send_word(64'hF2);
    send_word(64'hF3);
    send_eop();
    idle(2);
    send_sop(64'd5);
    send_word(64'hF4);
    send_eop();
    idle(3);
    expect_counts("t6", 3, 1, 1, 0, 3);
    expect_write("t6_w0", 0, 12'd83, 64'hF0);
    expect_write("t6_w1", 1, 12'd84, 64'hF1);
    expect_write("t6_w2", 2, 12'd85, 64'hF4);
    expect_enq("t6", 0, enq_word(3'd5, 12'd85, 12'd85, 13'd1, 1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/write_packer.md
# write_packer

Ingress-side counterpart of the read arbiter in the SRAM controller. It takes one packet stream framed as wr_sop / wr_vld / wr_eop, pulls one free SRAM address per data word from the free-list manager, and writes each word into SRAM. It chains the words into a linked list and, at end of packet, pushes one enqueue descriptor per packet into the manager's per-priority queues; that push is what later raises `prepared` on the read side.

## Interface
Parameters:
- num_of_priorities, 8, number of priority queues
- priority_width, 3, log2(num_of_priorities)
- address_width, 12, SRAM word address width
- arbiter_data_width, 64, data word width
- max_words, 64, maximum data words per packet (power of two, ≤ 2^address_width)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- wr_sop  in  1  one-cycle header strobe; wr_data carries header
- wr_vld  in  1  data word valid (contiguous, starts ≥1 cycle after wr_sop)
- wr_eop  in  1  one-cycle strobe, ≥1 cycle after last wr_vld
- wr_data  in  arbiter_data_width  header (on sop) / payload (on vld)
- wr_ready  out  1  informational: free_valid && state!=DROP
- free_addr  in  address_width  head of free list
- free_valid  in  1  free_addr usable this cycle
- free_pop  out  1  combinational; consume free_addr this cycle
- wea  out  1  SRAM write enable
- addra  out  address_width  SRAM write address
- dina  out  arbiter_data_width  SRAM write data
- link_we  out  1  next-pointer table write
- link_addr  out  address_width  previous word address
- link_data  out  address_width  current word address
- enq_valid  out  1  one-cycle descriptor strobe
- enq_priority  out  priority_width  queue index
- enq_head / enq_tail  out  address_width  first / last word address
- enq_len  out  address_width+1  word count (1..max_words)
- enq_drop  out  1  descriptor is a discard; manager returns chain to free list
- pkt_drop  out  1  one-cycle pulse per dropped packet

## Operation
- FSM states: IDLE, DATA, DROP.
- IDLE: on wr_sop, latch prio = wr_data[priority_width-1:0], clear len, → DATA. wr_vld/wr_eop without a preceding sop are ignored.
- DATA, accept = wr_vld && free_valid && len<max_words:
  - free_pop=1; register word into write stage.
  - On the first word, record head=free_addr; on every word, tail=free_addr.
  - For len>0, also issue a link write prev→cur.
  - len+1.
- DATA, wr_vld && !free_valid, or len==max_words (overflow): no pop, no write, → DROP.
- DATA, wr_eop:
  - len>0: enqueue {prio, head, tail, len, drop=0}.
  - len==0: pkt_drop only, no enqueue.
  - → IDLE.
- DATA, wr_sop (missing eop):
  - Close the current packet as a drop: enq_drop=1 if len>0, plus pkt_drop.
  - Latch the new header and stay in DATA with len=0.
- DROP: wr_vld words discarded, free_pop=0.
  - On wr_eop: pkt_drop, plus an enqueue with enq_drop=1 if len>0 (frees the chain); → IDLE.
  - On wr_sop: same drop close, then new header → DATA.
- Simultaneous wr_vld and wr_eop in one cycle: protocol violation. The word is accepted first, then eop handling applies using the updated len/tail.
- enq_priority is never checked against queue occupancy; the manager owns that.

## Timing
- Reset value of every registered output is 0: wea, addra, dina, link_*, enq_*, pkt_drop. State resets to IDLE, len/head/tail/prio to 0. Addresses popped before reset are not recovered; the manager resets simultaneously.
- free_pop is combinational in the accept cycle n.
- wea/addra/dina and link_we/link_addr/link_data are registered, valid at cycle n+1 for one cycle.
- wr_eop sampled at cycle m: enq_valid/pkt_drop asserted at m+1 for exactly one cycle. The last SRAM write (at ≤m) always precedes the enqueue.
- Back-to-back packets: sop may arrive the cycle after eop; full throughput of one word per cycle.
- Reset asserted mid-packet: the next cycle has all outputs 0 and state IDLE; the rest of the packet is ignored until the next sop.

## Test plan
- Single packet: sop hdr=5, 3 vld words D0..D2, free_addr 10,11,12, then eop. Required: wea at addra 10/11/12 with D0..D2; link writes 10→11 and 11→12; one enq_valid with prio 5, head 10, tail 12, len 3, drop 0.
- Back-to-back: two 1-word packets at prio 0 and 7, sop immediately after eop. Required: two enq pulses, each head==tail, len 1, correct priorities.
- Free list empty: free_valid drops before word 2 of a 4-word packet. Required: only word 1 written; at eop, enq_drop=1 with len 1 and head==tail; pkt_drop=1.
- Oversize: 65 words with max_words=64. Required: exactly 64 writes and pops; at eop, enq_drop=1 with len 64.
- Missing eop: sop, 2 words, sop (prio 3), 1 word, eop. Required: first packet drop descriptor with len 2; second packet normal enqueue with prio 3, len 1.
- Reset after 2 accepted words. Required: no enq_valid; all outputs 0 the next cycle; a following clean packet enqueues normally.
